// File: rtl/input_debounce.sv
// Synchronises, debounces and holds the board buttons and switches as stable levels,
// with registered one-cycle press/release pulses per button and a switch-change pulse.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int NBTN            = 5,
    parameter int NSW             = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] in_btn_raw,
    input  logic [NSW-1:0]  in_swi_raw,
    output logic [NBTN-1:0] out_butten,
    output logic [NSW-1:0]  out_swi,
    output logic [NBTN-1:0] out_btn_press,
    output logic [NBTN-1:0] out_btn_release,
    output logic            out_swi_changed
);

    localparam int NCH = NBTN + NSW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_p0;
    logic [NCH-1:0]   s2_p1;
    logic [NCH-1:0]   stb_p2;
    logic [NCH-1:0]   differ;
    logic [NCH-1:0]   accept;
    logic [CNT_W-1:0] cnt     [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];
    logic [NBTN-1:0]  press_p2;
    logic [NBTN-1:0]  release_p2;
    logic             swi_changed_p2;

    // Counter saturates at CNT_LAST by returning to zero on accept; never wraps.
    function automatic logic [CNT_W-1:0] cnt_step(input logic dif, input logic [CNT_W-1:0] c);
        if (!dif || (c == CNT_LAST))
            return '0;
        return c + CNT_W'(1);
    endfunction

    assign raw = {in_swi_raw, in_btn_raw};

    always_comb begin
        differ = s2_p1 ^ stb_p2;
        accept = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = cnt_step(differ[i], cnt[i]);
            accept[i]  = differ[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_p0          <= '0;
            s2_p1          <= '0;
            stb_p2         <= '0;
            press_p2       <= '0;
            release_p2     <= '0;
            swi_changed_p2 <= 1'b0;
            for (int i = 0; i < NCH; i++)
                cnt[i] <= '0;
        end else begin
            // stage p0/p1: two-flop synchroniser
            s1_p0 <= raw;
            s2_p1 <= s1_p0;
            // stage p2: accept flips the stable level toward s2, pulses coincide with it
            stb_p2         <= stb_p2 ^ accept;
            press_p2       <= accept[NBTN-1:0] & s2_p1[NBTN-1:0];
            release_p2     <= accept[NBTN-1:0] & ~s2_p1[NBTN-1:0];
            swi_changed_p2 <= |accept[NCH-1:NBTN];
            for (int i = 0; i < NCH; i++)
                cnt[i] <= cnt_nxt[i];
        end
    end

    assign out_butten      = stb_p2[NBTN-1:0];
    assign out_swi         = stb_p2[NCH-1:NBTN];
    assign out_btn_press   = press_p2;
    assign out_btn_release = release_p2;
    assign out_swi_changed = swi_changed_p2;

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: directed scenarios plus random bouncing inputs,
// checked every cycle against a sliding-window reference of the raw samples.
module tb_input_debounce;

    localparam int DC = 4;
    localparam int NB = 5;
    localparam int NS = 16;
    localparam int NC = NB + NS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] in_btn_raw = '0;
    logic [NS-1:0] in_swi_raw = '0;
    logic [NB-1:0] out_butten;
    logic [NS-1:0] out_swi;
    logic [NB-1:0] out_btn_press;
    logic [NB-1:0] out_btn_release;
    logic          out_swi_changed;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    input_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(3),
        .NBTN(NB),
        .NSW(NS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_btn_raw(in_btn_raw),
        .in_swi_raw(in_swi_raw),
        .out_butten(out_butten),
        .out_swi(out_swi),
        .out_btn_press(out_btn_press),
        .out_btn_release(out_btn_release),
        .out_swi_changed(out_swi_changed)
    );

    always #5 clk = ~clk;

    // Reference: a channel's level flips once the DC most recent synchronised
    // samples (raw samples from 2..DC+1 edges ago) all disagree with it.
    logic [NC-1:0] hist [DC+2];
    logic [NC-1:0] m_lvl;
    logic [NC-1:0] m_flip;
    logic [NB-1:0] m_press;
    logic [NB-1:0] m_rel;
    logic          m_swc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < DC + 2; j++) hist[j] = '0;
            m_lvl   = '0;
            m_press = '0;
            m_rel   = '0;
            m_swc   = 1'b0;
        end else begin
            for (int j = DC + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = {in_swi_raw, in_btn_raw};
            m_flip = '1;
            for (int j = 2; j <= DC + 1; j++) m_flip &= hist[j] ^ m_lvl;
            m_lvl   = m_lvl ^ m_flip;
            m_press = m_flip[NB-1:0] & m_lvl[NB-1:0];
            m_rel   = m_flip[NB-1:0] & ~m_lvl[NB-1:0];
            m_swc   = |m_flip[NC-1:NB];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("butten",  32'(out_butten),      32'(m_lvl[NB-1:0]));
            check("swi",     32'(out_swi),         32'(m_lvl[NC-1:NB]));
            check("press",   32'(out_btn_press),   32'(m_press));
            check("release", 32'(out_btn_release), 32'(m_rel));
            check("swi_chg", 32'(out_swi_changed), 32'(m_swc));
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b0;
        wait_neg(3);
        check("rst_butten", 32'(out_butten), 32'h0);
        check("rst_swi",    32'(out_swi),    32'h0);
        rst    = 1'b1;
        chk_en = 1'b1;
        wait_neg(20);
        check("idle_butten", 32'(out_butten), 32'h0);
        check("idle_press",  32'(out_btn_press), 32'h0);

        // Button 2 press: visible at the 6th falling edge after the sampling edge
        in_btn_raw = 5'b00100;
        wait_neg(5);
        check("btn2_early", 32'(out_butten), 32'h0);
        wait_neg(1);
        check("btn2_lvl",   32'(out_butten),    32'h04);
        check("btn2_press", 32'(out_btn_press), 32'h04);
        wait_neg(1);
        check("btn2_press_end", 32'(out_btn_press),   32'h0);
        check("btn2_no_rel",    32'(out_btn_release), 32'h0);
        in_btn_raw = 5'b00000;
        wait_neg(8);

        // Bounce on button 0, every run shorter than DC
        in_btn_raw[0] = 1'b1; wait_neg(3);
        in_btn_raw[0] = 1'b0; wait_neg(1);
        in_btn_raw[0] = 1'b1; wait_neg(3);
        in_btn_raw[0] = 1'b0; wait_neg(10);
        check("bounce_lvl", 32'(out_butten), 32'h0);

        // Switch bank change in one cycle
        in_swi_raw = 16'hA5C3;
        wait_neg(5);
        check("swi_early", 32'(out_swi), 32'h0);
        wait_neg(1);
        check("swi_lvl", 32'(out_swi),         32'hA5C3);
        check("swi_chg", 32'(out_swi_changed), 32'h1);
        wait_neg(1);
        check("swi_chg_end", 32'(out_swi_changed), 32'h0);

        // Button 4 press then release
        in_btn_raw = 5'b10000;
        wait_neg(10);
        check("btn4_lvl", 32'(out_butten), 32'h10);
        in_btn_raw = 5'b00000;
        wait_neg(5);
        check("btn4_rel_early", 32'(out_btn_release), 32'h0);
        wait_neg(1);
        check("btn4_rel",     32'(out_btn_release), 32'h10);
        check("btn4_lvl_off", 32'(out_butten),      32'h0);
        wait_neg(1);
        check("btn4_rel_end", 32'(out_btn_release), 32'h0);
        wait_neg(4);

        // Reset in the middle of button 1's count; switches still held at A5C3
        in_btn_raw = 5'b00010;
        wait_neg(4);
        #1 rst = 1'b0;
        #1;
        check("async_rst_swi",    32'(out_swi),    32'h0);
        check("async_rst_butten", 32'(out_butten), 32'h0);
        wait_neg(2);
        rst = 1'b1;
        wait_neg(5);
        check("post_rst_early", 32'(out_btn_press), 32'h0);
        wait_neg(1);
        check("post_rst_press", 32'(out_btn_press),   32'h02);
        check("post_rst_swchg", 32'(out_swi_changed), 32'h1);
        check("post_rst_swi",   32'(out_swi),         32'hA5C3);
        in_btn_raw = '0;
        in_swi_raw = '0;
        wait_neg(10);

        // Random bouncing inputs with occasional asynchronous resets
        for (int it = 0; it < 700; it++) begin
            in_btn_raw ^= NB'($urandom & $urandom);
            in_swi_raw ^= NS'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) begin
                in_btn_raw = NB'($urandom);
                in_swi_raw = NS'($urandom);
            end
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
            wait_neg($urandom_range(1, 8));
        end

        wait_neg(2);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
